ysyx_23060184_pipe_ctrl: RTL and testbench

Pipeline sequencer for the 5-stage core. Owns the per-stage valid bits (D, E, M, W) and the load enables of the IF/ID, ID/EXE, EXE/MEM and MEM/WB registers. Detects load-use hazards, CSR/ecall/mret serialisation, EXE-resolved redirects and LSU wait states, then issues stall and bubble decisions. It also produces the EXE forwarding selects and saturating stall and flush counters.

---
 rtl/ysyx_23060184_pipe_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_ysyx_23060184_pipe_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060184_pipe_ctrl.sv
// Pipeline sequencer: stage valids, register enables, hazard stalls/bubbles,
// redirect squash, LSU handshake FSM, EXE forwarding selects and counters.
module ysyx_23060184_pipe_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ifu_valid,
    output logic             ifu_ready,
    output logic             pc_redirect,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic             SerialD,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic             MemReadE,
    input  logic             TakenE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemAccM,
    output logic             lsu_valid,
    input  logic             lsu_ready,
    input  logic             lsu_done,
    output logic             enD,
    output logic             enE,
    output logic             enM,
    output logic             enW,
    output logic             vldD,
    output logic             vldE,
    output logic             vldM,
    output logic             vldW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        LSU_RUN  = 1'b0,
        LSU_WAIT = 1'b1
    } lsuState_t;

    lsuState_t lsuState;
    lsuState_t lsuNext;

    logic memReqM;
    logic freeze;
    logic redir;
    logic luse;
    logic ser;
    logic stallInc;
    logic flushInc;
    logic vldDNext;
    logic vldENext;
    logic vldMNext;
    logic vldWNext;
    logic fwdMemA;
    logic fwdWbA;
    logic fwdMemB;
    logic fwdWbB;

    // Hazard conditions; lsu_done only matters while MEM holds a memory op
    assign memReqM = vldM & MemAccM;
    assign freeze  = memReqM & ~lsu_done;
    assign redir   = vldE & TakenE;
    assign luse    = vldD & vldE & MemReadE & (RdE != 5'd0) &
                     ((RdE == Rs1D) | (RdE == Rs2D));
    assign ser     = vldD & SerialD & (vldE | vldM | vldW);

    // A squashed ID instruction cannot stall, so redirect masks ser/luse
    assign stallInc = freeze | (~redir & (ser | luse));
    assign flushInc = ~freeze & redir;

    // Forwarding: MEM result is younger and wins over WB
    assign fwdMemA = vldM & RegWriteM & (RdM != 5'd0) & (RdM == Rs1E);
    assign fwdWbA  = vldW & RegWriteW & (RdW != 5'd0) & (RdW == Rs1E);
    assign fwdMemB = vldM & RegWriteM & (RdM != 5'd0) & (RdM == Rs2E);
    assign fwdWbB  = vldW & RegWriteW & (RdW != 5'd0) & (RdW == Rs2E);

    assign ForwardAE = fwdMemA ? 2'b10 : (fwdWbA ? 2'b01 : 2'b00);
    assign ForwardBE = fwdMemB ? 2'b10 : (fwdWbB ? 2'b01 : 2'b00);

    // Stall/bubble/squash decision in priority freeze > redir > ser/luse > normal
    always_comb begin
        ifu_ready   = 1'b1;
        pc_redirect = 1'b0;
        enD         = 1'b1;
        enE         = 1'b1;
        enM         = 1'b1;
        enW         = 1'b1;
        vldDNext    = ifu_valid;
        vldENext    = vldD;
        vldMNext    = vldE;
        vldWNext    = vldM;
        if (freeze) begin
            ifu_ready = 1'b0;
            enD       = 1'b0;
            enE       = 1'b0;
            enM       = 1'b0;
            vldDNext  = vldD;
            vldENext  = vldE;
            vldMNext  = vldM;
            vldWNext  = 1'b0;
        end else if (redir) begin
            ifu_ready   = 1'b0;
            pc_redirect = 1'b1;
            vldDNext    = 1'b0;
            vldENext    = 1'b0;
            vldMNext    = 1'b1;
        end else if (ser | luse) begin
            ifu_ready = 1'b0;
            enD       = 1'b0;
            vldDNext  = vldD;
            vldENext  = 1'b0;
        end
    end

    // LSU handshake next state and request
    always_comb begin
        lsuNext   = lsuState;
        lsu_valid = 1'b0;
        case (lsuState)
            LSU_RUN: begin
                lsu_valid = memReqM;
                if (memReqM & lsu_ready & ~lsu_done) begin
                    lsuNext = LSU_WAIT;
                end
            end
            LSU_WAIT: begin
                if (memReqM & lsu_done) begin
                    lsuNext = LSU_RUN;
                end
            end
            default: lsuNext = LSU_RUN;
        endcase
    end

    // LSU state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lsuState <= LSU_RUN;
        end else begin
            lsuState <= lsuNext;
        end
    end

    // Stage valid bits
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vldD <= 1'b0;
            vldE <= 1'b0;
            vldM <= 1'b0;
            vldW <= 1'b0;
        end else begin
            vldD <= vldDNext;
            vldE <= vldENext;
            vldM <= vldMNext;
            vldW <= vldWNext;
        end
    end

    // Saturating stall and flush counters
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stallInc && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flushInc && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060184_pipe_ctrl.sv
// Directed scenarios for the pipeline sequencer; expected observations are
// queued per cycle and compared once the DUT outputs have settled.
module tb_ysyx_23060184_pipe_ctrl;

    localparam int unsigned CNT_W = 32;

    localparam int S_VLD = 0;   // {vldD,vldE,vldM,vldW}
    localparam int S_RDY = 1;
    localparam int S_RED = 2;
    localparam int S_EN  = 3;   // {enD,enE,enM,enW}
    localparam int S_LSU = 4;
    localparam int S_FA  = 5;
    localparam int S_FB  = 6;
    localparam int S_STL = 7;
    localparam int S_FLS = 8;

    logic             clk = 1'b0;
    logic             resetn;
    logic             ifu_valid;
    logic             ifu_ready;
    logic             pc_redirect;
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic             SerialD, MemReadE, TakenE;
    logic             RegWriteM, RegWriteW, MemAccM;
    logic             lsu_valid, lsu_ready, lsu_done;
    logic             enD, enE, enM, enW;
    logic             vldD, vldE, vldM, vldW;
    logic [1:0]       ForwardAE, ForwardBE;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] v;
    } exp_t;

    exp_t sb[$];
    int   nVec = 0;
    int   nMis = 0;

    always #5 clk = ~clk;

    ysyx_23060184_pipe_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn),
        .ifu_valid(ifu_valid), .ifu_ready(ifu_ready), .pc_redirect(pc_redirect),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .SerialD(SerialD),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .MemReadE(MemReadE), .TakenE(TakenE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemAccM(MemAccM),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_done(lsu_done),
        .enD(enD), .enE(enE), .enM(enM), .enW(enW),
        .vldD(vldD), .vldE(vldE), .vldM(vldM), .vldW(vldW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    function automatic logic [31:0] obs(int sel);
        case (sel)
            S_VLD:   return 32'({vldD, vldE, vldM, vldW});
            S_RDY:   return 32'(ifu_ready);
            S_RED:   return 32'(pc_redirect);
            S_EN:    return 32'({enD, enE, enM, enW});
            S_LSU:   return 32'(lsu_valid);
            S_FA:    return 32'(ForwardAE);
            S_FB:    return 32'(ForwardBE);
            S_STL:   return 32'(stall_cnt);
            S_FLS:   return 32'(flush_cnt);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nMis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, obs(e.sel), e.v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clr();
        ifu_valid = 1'b1;
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
        SerialD = 1'b0; MemReadE = 1'b0; TakenE = 1'b0;
        RegWriteM = 1'b0; RegWriteW = 1'b0; MemAccM = 1'b0;
        lsu_ready = 1'b0; lsu_done = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] fillExp [5];
        fillExp = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111};

        resetn = 1'b0;
        clr();
        @(negedge clk);
        push("rst_vld", S_VLD, 0);
        push("rst_rdy", S_RDY, 1);
        push("rst_red", S_RED, 0);
        push("rst_en",  S_EN,  4'b1111);
        push("rst_lsu", S_LSU, 0);
        push("rst_stl", S_STL, 0);
        push("rst_fls", S_FLS, 0);
        drain();
        tick();
        resetn = 1'b1;

        // Fill from reset, one stage per cycle
        for (int i = 0; i < 5; i++) begin
            push($sformatf("fill%0d_vld", i), S_VLD, 32'(fillExp[i]));
            if (i == 4) push("fill_stl", S_STL, 0);
            drain();
            tick();
        end

        // Load-use: one bubble into EXE
        clr(); MemReadE = 1'b1; RdE = 5'd5; Rs1D = 5'd5;
        push("lu_rdy", S_RDY, 0);
        push("lu_en",  S_EN,  4'b0111);
        push("lu_red", S_RED, 0);
        drain();
        tick();
        clr(); RdM = 5'd5; RegWriteM = 1'b1; MemAccM = 1'b1; lsu_ready = 1'b1; lsu_done = 1'b1;
        push("lu1_vld", S_VLD, 4'b1011);
        push("lu1_stl", S_STL, 1);
        push("lu1_lsu", S_LSU, 1);
        push("lu1_en",  S_EN,  4'b1111);
        push("lu1_rdy", S_RDY, 1);
        drain();
        tick();
        clr(); Rs1E = 5'd5; RdW = 5'd5; RegWriteW = 1'b1; RdM = 5'd5; RegWriteM = 1'b1;
        push("lu2_vld", S_VLD, 4'b1101);
        push("lu2_fa",  S_FA,  2'b01);
        push("lu2_fb",  S_FB,  2'b00);
        drain();
        tick();

        // Redirect together with load-use: redirect wins
        clr(); TakenE = 1'b1; MemReadE = 1'b1; RdE = 5'd3; Rs2D = 5'd3;
        push("rd_vld", S_VLD, 4'b1110);
        push("rd_red", S_RED, 1);
        push("rd_rdy", S_RDY, 0);
        push("rd_en",  S_EN,  4'b1111);
        drain();
        tick();
        clr();
        push("rd1_vld", S_VLD, 4'b0011);
        push("rd1_red", S_RED, 0);
        push("rd1_rdy", S_RDY, 1);
        push("rd1_fls", S_FLS, 1);
        push("rd1_stl", S_STL, 1);
        drain();
        tick();
        clr();
        push("rd2_vld", S_VLD, 4'b1001);
        drain();
        tick();
        push("rd3_vld", S_VLD, 4'b1100);
        drain();
        tick();

        // Store waits on LSU with a redirect pending behind the freeze
        clr(); MemAccM = 1'b1; lsu_ready = 1'b1; TakenE = 1'b1;
        push("st0_vld", S_VLD, 4'b1110);
        push("st0_lsu", S_LSU, 1);
        push("st0_en",  S_EN,  4'b0001);
        push("st0_rdy", S_RDY, 0);
        push("st0_red", S_RED, 0);
        drain();
        tick();
        for (int k = 1; k <= 2; k++) begin
            clr(); MemAccM = 1'b1; TakenE = 1'b1;
            push($sformatf("st%0d_vld", k), S_VLD, 4'b1110);
            push($sformatf("st%0d_lsu", k), S_LSU, 0);
            push($sformatf("st%0d_en", k),  S_EN,  4'b0001);
            push($sformatf("st%0d_red", k), S_RED, 0);
            push($sformatf("st%0d_stl", k), S_STL, 32'(1 + k));
            drain();
            tick();
        end
        clr(); MemAccM = 1'b1; TakenE = 1'b1; lsu_done = 1'b1;
        push("st3_vld", S_VLD, 4'b1110);
        push("st3_lsu", S_LSU, 0);
        push("st3_red", S_RED, 1);
        push("st3_en",  S_EN,  4'b1111);
        push("st3_stl", S_STL, 4);
        push("st3_fls", S_FLS, 1);
        drain();
        tick();
        clr(); MemAccM = 1'b1; lsu_done = 1'b1;
        push("st4_vld", S_VLD, 4'b0011);
        push("st4_lsu", S_LSU, 1);
        push("st4_stl", S_STL, 4);
        push("st4_fls", S_FLS, 2);
        drain();
        tick();

        // Serialising instruction waits for E, M, W to drain
        clr();
        push("sr_pre", S_VLD, 4'b1001);
        drain();
        tick(); tick(); tick();
        SerialD = 1'b1;
        push("sr0_vld", S_VLD, 4'b1111);
        push("sr0_rdy", S_RDY, 0);
        push("sr0_en",  S_EN,  4'b0111);
        drain();
        tick();
        push("sr1_vld", S_VLD, 4'b1011);
        push("sr1_stl", S_STL, 5);
        drain();
        tick();
        push("sr2_vld", S_VLD, 4'b1001);
        push("sr2_rdy", S_RDY, 0);
        drain();
        tick();
        push("sr3_vld", S_VLD, 4'b1000);
        push("sr3_rdy", S_RDY, 1);
        push("sr3_en",  S_EN,  4'b1111);
        push("sr3_stl", S_STL, 7);
        drain();
        tick();
        clr();
        push("sr4_vld", S_VLD, 4'b1100);
        drain();
        tick(); tick();

        // Forwarding priority
        clr(); Rs1E = 5'd7; RdM = 5'd7; RdW = 5'd7; RegWriteM = 1'b1; RegWriteW = 1'b1;
        push("fw_vld", S_VLD, 4'b1111);
        push("fw_fa",  S_FA,  2'b10);
        push("fw_fb",  S_FB,  2'b00);
        drain();
        Rs2E = 5'd7;
        push("fw_fb_mem", S_FB, 2'b10);
        drain();
        RdM = 5'd0;
        push("fw_fa_wb", S_FA, 2'b01);
        push("fw_fb_wb", S_FB, 2'b01);
        drain();
        RegWriteW = 1'b0;
        push("fw_fa_rf", S_FA, 2'b00);
        drain();
        tick();

        // Reset in the middle of an LSU wait
        clr(); MemAccM = 1'b1; lsu_ready = 1'b1;
        push("mr_lsu", S_LSU, 1);
        drain();
        tick();
        clr(); MemAccM = 1'b1;
        push("mr_wait_lsu", S_LSU, 0);
        push("mr_wait_stl", S_STL, 8);
        drain();
        resetn = 1'b0;
        push("mr_vld", S_VLD, 0);
        push("mr_stl", S_STL, 0);
        push("mr_fls", S_FLS, 0);
        push("mr_rdy", S_RDY, 1);
        drain();
        tick();
        resetn = 1'b1;
        clr();
        tick(); tick(); tick();
        MemAccM = 1'b1;
        push("mr_run_vld", S_VLD, 4'b1110);
        push("mr_run_lsu", S_LSU, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
